// File: rtl/fetch_queue.sv
// Front-end fetch queue: single-outstanding I-cache requester feeding a small
// instruction FIFO whose head is presented to dispatch as an IF/ID packet.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef NOP
`define NOP 32'h0000_0013
`endif

package fetch_queue_pkg;
   typedef struct packed {
      logic [31:0]      inst;
      logic [`XLEN-1:0] pc;
      logic [`XLEN-1:0] npc;
      logic             valid;
   } if_id_packet_t;
endpackage

module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned      DEPTH    = 4,
   parameter logic [`XLEN-1:0] RESET_PC = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic             rollback,
   input  logic [`XLEN-1:0] rollback_pc,
   output logic             icache_req_valid,
   output logic [`XLEN-1:0] icache_req_addr,
   input  logic             icache_req_ready,
   input  logic             icache_resp_valid,
   input  logic [31:0]      icache_resp_inst,
   output if_id_packet_t    if_id_packet
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   localparam logic [1:0] ST_REQ  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [`XLEN-1:0] fetch_pc;
   logic [`XLEN-1:0] req_pc;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic [31:0]      mem_inst [DEPTH];
   logic [`XLEN-1:0] mem_pc   [DEPTH];

   logic req_fire;
   logic push;
   logic pop;
   logic fifo_empty;

   // Only REQ can issue, so an empty slot alone is the credit for the next response.
   assign fifo_empty       = (count == '0);
   assign icache_req_valid = (state == ST_REQ) && (count < FULL_COUNT) && !rollback;
   assign icache_req_addr  = fetch_pc;
   assign req_fire         = icache_req_valid && icache_req_ready;
   assign push             = (state == ST_WAIT) && icache_resp_valid && !rollback;
   assign pop              = !fifo_empty && !stall && !rollback;

   always_comb begin
      // NOTE: default first so no path leaves state_next unassigned (no latch).
      state_next = state;
      if (rollback) begin
         // A response landing in the rollback cycle itself settles the outstanding request.
         if (state == ST_REQ || icache_resp_valid) state_next = ST_REQ;
         else                                      state_next = ST_DROP;
      end else begin
         case (state)
            ST_REQ:  if (req_fire)          state_next = ST_WAIT;
            ST_WAIT: if (icache_resp_valid) state_next = ST_REQ;
            ST_DROP: if (icache_resp_valid) state_next = ST_REQ;
            default:                        state_next = ST_REQ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_REQ;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         state <= state_next;
         if (rollback) begin
            fetch_pc <= rollback_pc;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
         end else begin
            if (req_fire) begin
               req_pc   <= fetch_pc;
               fetch_pc <= fetch_pc + `XLEN'(4);
            end
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
         end
      end
   end

   // NOTE: storage is not reset; count alone decides whether an entry is visible.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_inst[tail] <= icache_resp_inst;
         mem_pc[tail]   <= req_pc;
      end
   end

   always_comb begin
      if_id_packet = '{inst: `NOP, pc: '0, npc: '0, valid: 1'b0};
      if (!fifo_empty) begin
         if_id_packet.inst  = mem_inst[head];
         if_id_packet.pc    = mem_pc[head];
         if_id_packet.npc   = mem_pc[head] + `XLEN'(4);
         if_id_packet.valid = !rollback;
      end
   end

   a_count_bound: assert property (@(posedge clock) disable iff (reset)
      count <= FULL_COUNT);

   a_addr_hold: assert property (@(posedge clock) disable iff (reset)
      (icache_req_valid && !icache_req_ready) |=> $stable(icache_req_addr));

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Front-end fetch unit; producer side of the IF_ID_PACKET / stall handshake consumed by dispatch.
- Holds the fetch PC and issues single-outstanding instruction requests to the I-memory/icache.
- Buffers returned instructions in a small FIFO and presents the FIFO head to dispatch, holding it while dispatch stalls.
- Flushes everything and redirects fetch on rollback.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >=2
RESET_PC, 0, fetch PC after reset

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
stall  in  1  from dispatch; 1 = head not consumed this cycle
rollback  in  1  flush and redirect; highest priority
rollback_pc  in  `XLEN  redirect target
icache_req_valid  out  1  request valid
icache_req_addr  out  `XLEN  request address (current fetch PC)
icache_req_ready  in  1  request accepted this cycle when valid&ready
icache_resp_valid  in  1  response valid; one per accepted request, >=1 cycle after acceptance
icache_resp_inst  in  32  returned instruction
if_id_packet  out  IF_ID_PACKET  {inst, PC, NPC, valid} to dispatch

Behaviour:
- Reset is asynchronous and takes effect immediately:
  - fetch_pc=RESET_PC; FIFO empty (head/tail/count=0); state=REQ; req_pc=0.
  - if_id_packet.valid=0, inst=`NOP, PC=NPC=0.
- FSM states:
  - REQ: may issue a request.
  - WAIT: one request outstanding.
  - DROP: outstanding response must be discarded.
- icache_req_valid = (state==REQ) && (count < DEPTH) && !rollback. The outstanding request is counted as a credit, so count never exceeds DEPTH.
- icache_req_addr = fetch_pc.
  - Must hold stable while req_valid=1 and ready=0.
  - May change only on rollback.
- REQ, valid&&ready: req_pc <= fetch_pc; fetch_pc <= fetch_pc+4 (wraps modulo 2^`XLEN); -> WAIT.
- WAIT, resp_valid: push {inst=icache_resp_inst, PC=req_pc, NPC=req_pc+4, valid=1} at tail; -> REQ.
  - The pushed entry is visible on if_id_packet no earlier than the next cycle; there is no bypass.
- DROP, resp_valid: discard the response, no push; -> REQ.
- Output:
  - if_id_packet = FIFO head when count>0, else valid=0 with inst=`NOP, PC=NPC=0.
  - valid is forced to 0 combinationally in a rollback cycle.
- Pop: when count>0 && !stall && !rollback, head advances by 1 (wraps modulo DEPTH).
  - Push and pop in the same cycle leave count unchanged.
- stall=1: head entry and its fields are held unchanged every cycle.
  - Fetch continues until credits are exhausted, then icache_req_valid=0.
- Rollback (sampled at the clock edge) overrides push, pop and request acceptance:
  - FIFO emptied (count=0, head=tail=0).
  - fetch_pc <= rollback_pc.
  - State WAIT -> DROP. Any response arriving in the rollback cycle itself is discarded and the state goes to REQ.
  - State REQ -> REQ. No request is accepted in the rollback cycle because req_valid=0.
  - State DROP -> DROP.
  - A first request to rollback_pc is issued the cycle after rollback, unless a drop is still pending.
- Back-to-back rollbacks: last rollback_pc wins.
- A response while in REQ is illegal; the bench flags it as an error.
- Pointers use $clog2(DEPTH) bits; count uses $clog2(DEPTH)+1 bits.
- Area target: 120-400 lines RTL. Flops: FIFO, pointers, count, fetch_pc, req_pc, 2-bit state.

Test Plan:
1. Hold reset, then release; ready=1 -> cycle 0 shows valid=0, req_valid=1, addr=0. After release, addr advances 0,4,8 on each acceptance.
2. Stream with ready=1, 1-cycle response, stall=0, insts 0xA,0xB,0xC -> output packets are, in order:
   - {0xA, PC 0, NPC 4}
   - {0xB, PC 4, NPC 8}
   - {0xC, PC 8, NPC 12}
   - each valid=1, each visible one cycle after its response.
3. stall=1 held, DEPTH=4:
   - After 4 responses, req_valid=0 and the head stays {PC 0} for 10 cycles.
   - Drop stall -> PCs 0,4,8,12 drain, one per cycle, and fetch resumes at 16.
4. Rollback while WAIT (request for PC 8 outstanding), rollback_pc=0x100:
   - Output valid=0 in the rollback cycle.
   - The PC-8 response is dropped.
   - The next request addr is 0x100; the first output packet is PC 0x100, NPC 0x104.
5. icache_req_ready=0 for 3 cycles with req_valid=1, addr=0x20 -> addr stays 0x20 and fetch_pc does not advance. Accepted on the 4th cycle; the next addr is 0x24.
6. Assert reset asynchronously between clock edges while 3 entries are buffered -> if_id_packet.valid=0 before the next edge. After release, fetch restarts at RESET_PC with an empty FIFO.
